// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer feeding an external 8-bit combinational ALU.
// It owns the 4x8 register file, the registered ALU inputs and the result handshake.
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [4:0]       alu_s,
    input  logic [7:0]       alu_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [1:0]       res_rd,
    output logic             res_zero,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam logic [4:0] S_TRANSFER = 5'b11000;
    localparam logic [4:0] S_RESET    = 5'b10000;

    logic [1:0] state;
    logic [7:0] rf [4];
    logic [1:0] rd_q;
    logic       accept;

    logic       is_ldi;
    logic [1:0] ldi_rd;
    logic [7:0] ldi_imm;
    logic [4:0] op_s;
    logic [1:0] op_rd;
    logic [1:0] op_ra;
    logic [1:0] op_rb;

    // Padding fields of both instruction formats carry no information.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[12:8], instr[3:0]};

    assign is_ldi  = instr[15];
    assign ldi_rd  = instr[14:13];
    assign ldi_imm = instr[7:0];
    assign op_s    = instr[14:10];
    assign op_rd   = instr[9:8];
    assign op_ra   = instr[7:6];
    assign op_rb   = instr[5:4];

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_q      <= 2'd0;
            alu_a     <= 8'd0;
            alu_b     <= 8'd0;
            alu_s     <= S_RESET;
            res_valid <= 1'b0;
            res_data  <= 8'd0;
            res_rd    <= 2'd0;
            res_zero  <= 1'b0;
            retired   <= '0;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 8'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_ldi) begin
                            rd_q  <= ldi_rd;
                            alu_a <= ldi_imm;
                            alu_b <= 8'd0;
                            alu_s <= S_TRANSFER;
                        end else begin
                            rd_q  <= op_rd;
                            alu_a <= rf[op_ra];
                            alu_b <= rf[op_rb];
                            alu_s <= op_s;
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Write-back is unconditional so the next instruction sees the new value.
                    rf[rd_q]  <= alu_f;
                    res_data  <= alu_f;
                    res_rd    <= rd_q;
                    res_zero  <= (alu_f == 8'd0);
                    res_valid <= 1'b1;
                    state     <= WB;
                end
                WB: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        retired   <= retired + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
